uart_txq: RTL and testbench

Byte queue and start/ready sequencer sitting directly upstream of the serial transmitter. Accepts bytes from the system side in single-cycle write strobes, buffers them in a circular FIFO, and hands them one at a time to the transmitter through its start/data/ready handshake. This lets producers such as string senders and the CPU bus burst data without polling transmitter readiness per byte.

---
 rtl/uart_txq_pkg.sv | 19 +
 rtl/uart_txq_fifo.sv | 88 ++++++++
 rtl/uart_txq.sv | 114 +++++++++++
 tb/tb_uart_txq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_txq_pkg.sv
// ---------------------------------------------------------------------------
// uart_txq_pkg
// Shared definitions for the UART transmit queue:
//   - txq_state_t            : sequencer state encoding
//   - TXQ_DEPTH_LOG2_DEFAULT : default log2 of the queue depth
// No ports (package).
// ---------------------------------------------------------------------------
package uart_txq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } txq_state_t;

    localparam int TXQ_DEPTH_LOG2_DEFAULT = 4;

endpackage : uart_txq_pkg

// File: rtl/uart_txq_fifo.sv
// ---------------------------------------------------------------------------
// uart_txq_fifo
// Circular byte FIFO of 2**DEPTH_LOG2 entries with a registered read port.
// The read register is loaded with the head entry on every accepted pop, so
// it serves directly as the byte presented to the transmitter.
//
// Ports:
//   clk    in   system clock
//   rstn   in   synchronous active-low reset
//   wr     in   write strobe (ignored while full)
//   wdata  in   byte to enqueue
//   pop    in   remove head entry (ignored while empty)
//   rdata  out  head byte captured at the last pop (0 after reset)
//   full   out  queue holds 2**DEPTH_LOG2 bytes
//   empty  out  queue holds 0 bytes
// ---------------------------------------------------------------------------
module uart_txq_fifo
    import uart_txq_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_reg;
    logic [DEPTH_LOG2-1:0] rp_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic [7:0]            rdata_reg;
    logic                  wr_en;
    logic                  pop_en;

    // Full is judged on the registered count, so a write arriving while full
    // is dropped even if a pop frees a slot at the same edge.
    assign full   = (count_reg == CNT_FULL);
    assign empty  = (count_reg == '0);
    assign wr_en  = wr && !full;
    assign pop_en = pop && !empty;
    assign rdata  = rdata_reg;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop_en})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage kept free of reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            rdata_reg <= 8'h00;
        end else begin
            count_reg <= count_next;
            if (wr_en) begin
                wp_reg <= wp_reg + PTR_ONE;
            end
            if (pop_en) begin
                rp_reg    <= rp_reg + PTR_ONE;
                rdata_reg <= mem[rp_reg];
            end
        end
    end

endmodule : uart_txq_fifo

// File: rtl/uart_txq.sv
// ---------------------------------------------------------------------------
// uart_txq
// Byte queue plus start/ready sequencer in front of a serial transmitter.
// Bytes written with single-cycle strobes are buffered and handed to the
// transmitter one at a time via tx_start/tx_data, waiting for tx_ready to
// drop and return between bytes.
//
// Build option: define TXQ_OVF_EN to add the sticky overflow flag port ovf.
//
// Ports:
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   wr        in   write strobe, one byte per cycle
//   wdata     in   byte to enqueue
//   full      out  queue holds 2**DEPTH_LOG2 bytes
//   empty     out  queue holds no bytes
//   busy      out  queue non-empty or sequencer not idle
//   tx_ready  in   transmitter idle
//   tx_start  out  registered one-cycle start pulse
//   tx_data   out  registered byte, held until the next start
//   ovf       out  sticky overflow flag (TXQ_OVF_EN only)
// ---------------------------------------------------------------------------
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       empty,
    output logic       busy,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data
`ifdef TXQ_OVF_EN
    ,
    output logic       ovf
`endif
);

    txq_state_t state_reg;
    txq_state_t state_next;
    logic       tx_start_reg;
    logic       tx_start_next;
    logic       pop;

    uart_txq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (wr),
        .wdata (wdata),
        .pop   (pop),
        .rdata (tx_data),
        .full  (full),
        .empty (empty)
    );

    // State register; tx_start is registered alongside it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            tx_start_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= tx_start_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (!empty && tx_ready) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!tx_ready) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_ready) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Output logic: the pop loads tx_data in the FIFO read register at the
    // same edge that raises tx_start, so data and strobe align.
    always_comb begin
        pop           = 1'b0;
        tx_start_next = 1'b0;
        if (state_reg == ST_IDLE && !empty && tx_ready) begin
            pop           = 1'b1;
            tx_start_next = 1'b1;
        end
    end

    assign tx_start = tx_start_reg;
    assign busy     = !empty || (state_reg != ST_IDLE);

`ifdef TXQ_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_reg <= 1'b0;
        end else if (wr && full) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule : uart_txq

// File: tb/tb_uart_txq.sv
// ---------------------------------------------------------------------------
// tb_uart_txq
// Directed testbench for uart_txq (DEPTH_LOG2 = 4) with a simple transmitter
// model: ready drops the cycle after tx_start and returns hold_len+1 cycles
// later, unless stalled. block forces tx_ready low from outside the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_txq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr;
    logic [7:0] wdata;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
`ifdef TXQ_OVF_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic       model_ready;
    logic       block;
    logic       stall;
    int         hold_len;
    int         hold;
    int         cyc = 0;
    logic [7:0] log_q[$];
    int         start_q[$];

    always #5 clk = ~clk;

    uart_txq #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr       (wr),
        .wdata    (wdata),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data)
`ifdef TXQ_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    assign tx_ready = model_ready && !block;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: captures the byte at the edge ending the start cycle.
    always @(posedge clk) begin
        if (!rstn) begin
            model_ready <= 1'b1;
            hold        <= 0;
        end else if (tx_start) begin
            model_ready <= 1'b0;
            hold        <= hold_len;
            log_q.push_back(tx_data);
            start_q.push_back(cyc);
        end else if (!model_ready && !stall) begin
            if (hold == 0) model_ready <= 1'b1;
            else           hold <= hold - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr    = 1'b1;
        wdata = b;
        tick();
        wr    = 1'b0;
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int i = 0;
        while (log_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk(tag, log_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while ((busy || !tx_ready) && i < budget) begin
            tick();
            i++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] hello [6];
        int         i;
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h0A;

        rstn = 1'b0; wr = 1'b0; wdata = 8'h00;
        block = 1'b0; stall = 1'b0; hold_len = 4;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state and quiet idle.
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
`ifdef TXQ_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        repeat (100) tick();
        chk("idle_no_start", log_q.size(), 0);

        // Single byte: start two cycles after the write.
        hold_len = 50;
        write_byte(8'h41);
        chk("one_n1_start", tx_start, 1'b0);
        chk("one_n1_empty", empty, 1'b0);
        tick();
        chk("one_n2_start", tx_start, 1'b1);
        chk("one_n2_data", tx_data, 8'h41);
        chk("one_n2_busy", busy, 1'b1);
        tick();
        chk("one_n3_start", tx_start, 1'b0);
        chk("one_n3_data", tx_data, 8'h41);
        chk("one_n3_ready", tx_ready, 1'b0);
        i = 0;
        while (!tx_ready && i < 200) begin
            tick();
            i++;
        end
        chk("one_ready_back", tx_ready, 1'b1);
        chk("one_busy_wait_done", busy, 1'b1);
        tick();
        chk("one_busy_fall", busy, 1'b0);
        chk("one_count", log_q.size(), 1);

        // Burst into a stalled transmitter: 0x30..0x40 accepted, 0x50 dropped.
        hold_len = 3;
        stall    = 1'b1;
        log_q.delete();
        start_q.delete();
        for (int k = 0; k < 17; k++) begin
            wr    = 1'b1;
            wdata = 8'h30 + 8'(k);
            tick();
        end
        wr = 1'b0;
        chk("burst_full", full, 1'b1);
`ifdef TXQ_OVF_EN
        chk("burst_ovf_before", ovf, 1'b0);
`endif
        write_byte(8'h50);
        chk("burst_full_after_drop", full, 1'b1);
`ifdef TXQ_OVF_EN
        chk("burst_ovf", ovf, 1'b1);
`endif
        chk("burst_first_popped", log_q.size(), 1);
        chk("burst_first_byte", log_q[0], 8'h30);
        stall = 1'b0;
        wait_log("burst_drain", 17, 1000);
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("burst_order_%0d", k), log_q[k], 8'h30 + 8'(k));
        end
        wait_idle("burst_idle", 100);
        chk("burst_empty", empty, 1'b1);

        // Write while popping at full, three wrap-around rounds.
        for (int r = 0; r < 3; r++) begin
            log_q.delete();
            block = 1'b1;
            for (int k = 0; k < 16; k++) begin
                wr    = 1'b1;
                wdata = 8'hA0 + 8'(r * 16 + k);
                tick();
            end
            wr = 1'b0;
            chk($sformatf("wrap%0d_full", r), full, 1'b1);
            chk($sformatf("wrap%0d_no_start", r), log_q.size(), 0);
            wr    = 1'b1;
            wdata = 8'h5A;
            block = 1'b0;
            tick();
            wr = 1'b0;
            chk($sformatf("wrap%0d_full_after_pop", r), full, 1'b0);
            chk($sformatf("wrap%0d_start", r), tx_start, 1'b1);
            wait_log($sformatf("wrap%0d_drain", r), 16, 1000);
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("wrap%0d_byte%0d", r, k), log_q[k], 8'hA0 + 8'(r * 16 + k));
            end
            wait_idle($sformatf("wrap%0d_idle", r), 100);
            chk($sformatf("wrap%0d_extra", r), log_q.size(), 16);
        end

        // Reset while in WAIT_DONE with 5 bytes queued.
        hold_len = 50;
        log_q.delete();
        for (int k = 0; k < 6; k++) begin
            wr    = 1'b1;
            wdata = 8'hC0 + 8'(k);
            tick();
        end
        wr = 1'b0;
        repeat (10) tick();
        chk("mrst_pre_busy", busy, 1'b1);
        chk("mrst_pre_ready", tx_ready, 1'b0);
        chk("mrst_pre_sent", log_q.size(), 1);
        rstn = 1'b0;
        tick();
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_tx_start", tx_start, 1'b0);
        chk("mrst_full", full, 1'b0);
        chk("mrst_tx_data", tx_data, 8'h00);
`ifdef TXQ_OVF_EN
        chk("mrst_ovf", ovf, 1'b0);
`endif
        rstn = 1'b1;
        log_q.delete();
        repeat (100) tick();
        chk("mrst_no_stale", log_q.size(), 0);
        chk("mrst_idle", busy, 1'b0);

        // "Hello\n": order and frame-to-frame spacing (hold + 4 cycles).
        hold_len = 20;
        log_q.delete();
        start_q.delete();
        for (int k = 0; k < 6; k++) begin
            wr    = 1'b1;
            wdata = hello[k];
            tick();
        end
        wr = 1'b0;
        wait_log("hello_drain", 6, 600);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("hello_byte%0d", k), log_q[k], hello[k]);
        end
        for (int k = 1; k < 6; k++) begin
            chk($sformatf("hello_gap%0d", k), start_q[k] - start_q[k-1], 24);
        end
        wait_idle("hello_idle", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_txq
